// File: rtl/dmem_bridge.sv
// Bridges the MEM stage's level-held data-memory request onto a valid/ready request channel and a response channel.
// Optional watchdog timeout is enabled with `define DMEM_TIMEOUT_EN.
module dmem_bridge #(
  parameter int ADDR_W         = 32,
  parameter int DATA_W         = 32,
  parameter int TIMEOUT_CYCLES = 256
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                ce_i,
  input  logic                we_i,
  input  logic [DATA_W/8-1:0] sel_i,
  input  logic [ADDR_W-1:0]   addr_i,
  input  logic [DATA_W-1:0]   wdata_i,
  input  logic                flush_i,
  output logic [DATA_W-1:0]   rdata_o,
  output logic                stall_o,
  output logic                req_valid_o,
  input  logic                req_ready_i,
  output logic                req_we_o,
  output logic [ADDR_W-1:0]   req_addr_o,
  output logic [DATA_W/8-1:0] req_wstrb_o,
  output logic [DATA_W-1:0]   req_wdata_o,
  input  logic                resp_valid_i,
  input  logic [DATA_W-1:0]   resp_data_i,
  output logic                err_o
);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_REQ   = 3'd1;
  localparam logic [2:0] S_RESP  = 3'd2;
  localparam logic [2:0] S_DONE  = 3'd3;
  localparam logic [2:0] S_DRAIN = 3'd4;

  logic [2:0]          r_state;
  logic                r_we;
  logic [ADDR_W-1:0]   r_addr;
  logic [DATA_W/8-1:0] r_wstrb;
  logic [DATA_W-1:0]   r_wdata;
  logic [DATA_W-1:0]   r_rdata;
  logic                w_expire;
  logic                w_stall;

`ifdef DMEM_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYCLES) + 1;

  logic [CNT_W-1:0] r_count;
  logic             r_err;
  logic             w_atLimit;

  assign w_atLimit = (r_count == CNT_W'(TIMEOUT_CYCLES - 1));

  // Expiry only counts when the access is not completing or being flushed in the same cycle.
  always_comb begin
    w_expire = 1'b0;
    case (r_state)
      S_REQ:   w_expire = w_atLimit && !req_ready_i && !flush_i;
      S_RESP:  w_expire = w_atLimit && !resp_valid_i && !flush_i;
      S_DRAIN: w_expire = w_atLimit && !resp_valid_i;
      default: w_expire = 1'b0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_count <= '0;
      r_err   <= 1'b0;
    end else begin
      r_err <= w_expire;
      if (r_state == S_IDLE)
        r_count <= '0;
      else if (r_state == S_REQ || r_state == S_RESP || r_state == S_DRAIN)
        r_count <= r_count + CNT_W'(1);
    end
  end

  assign err_o = r_err;
`else
  assign w_expire = 1'b0;
  assign err_o    = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_we    <= 1'b0;
      r_addr  <= '0;
      r_wstrb <= '0;
      r_wdata <= '0;
      r_rdata <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (ce_i && !flush_i) begin
            r_we    <= we_i;
            r_addr  <= addr_i & ~ADDR_W'(3);
            r_wstrb <= sel_i;
            r_wdata <= wdata_i;
            r_state <= S_REQ;
          end
        end
        S_REQ: begin
          if (req_ready_i) begin
            r_state <= flush_i ? S_DRAIN : S_RESP;
          end else if (flush_i) begin
            r_state <= S_IDLE;
          end else if (w_expire) begin
            if (!r_we) r_rdata <= '0;
            r_state <= S_DONE;
          end
        end
        S_RESP: begin
          if (resp_valid_i) begin
            if (!r_we) r_rdata <= resp_data_i;
            r_state <= flush_i ? S_IDLE : S_DONE;
          end else if (flush_i) begin
            r_state <= S_DRAIN;
          end else if (w_expire) begin
            if (!r_we) r_rdata <= '0;
            r_state <= S_DONE;
          end
        end
        S_DRAIN: begin
          if (resp_valid_i || w_expire) r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  // A flush releases the pipeline immediately, except while draining a response already in flight.
  always_comb begin
    w_stall = 1'b0;
    case (r_state)
      S_IDLE:         w_stall = ce_i && !flush_i;
      S_REQ, S_RESP:  w_stall = !flush_i;
      S_DRAIN:        w_stall = 1'b1;
      default:        w_stall = 1'b0;
    endcase
  end

  assign stall_o     = w_stall;
  assign req_valid_o = (r_state == S_REQ);
  assign req_we_o    = r_we;
  assign req_addr_o  = r_addr;
  assign req_wstrb_o = r_wstrb;
  assign req_wdata_o = r_wdata;
  assign rdata_o     = r_rdata;

endmodule

// File: tb/tb_dmem_bridge.sv
// Self-checking bench for dmem_bridge: scoreboarded loads/stores, backpressure, flushes, reset and (with DMEM_TIMEOUT_EN) the watchdog.
module tb_dmem_bridge;

  typedef struct packed {
    logic        we;
    logic [31:0] addr;
    logic [3:0]  strb;
    logic [31:0] wdata;
  } reqExp_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        ce_i, we_i, flush_i, req_ready_i, resp_valid_i;
  logic [3:0]  sel_i;
  logic [31:0] addr_i, wdata_i, resp_data_i;
  logic [31:0] rdata_o, req_addr_o, req_wdata_o;
  logic        stall_o, req_valid_o, req_we_o, err_o;
  logic [3:0]  req_wstrb_o;

  int          nChecks = 0;
  int          nFails  = 0;
  logic [31:0] modelRdata = '0;
  reqExp_t     reqQ[$];
  logic [31:0] rdQ[$];

  dmem_bridge #(.ADDR_W(32), .DATA_W(32), .TIMEOUT_CYCLES(8)) dut (
    .clk(clk), .rst(rst), .ce_i(ce_i), .we_i(we_i), .sel_i(sel_i),
    .addr_i(addr_i), .wdata_i(wdata_i), .flush_i(flush_i),
    .rdata_o(rdata_o), .stall_o(stall_o), .req_valid_o(req_valid_o),
    .req_ready_i(req_ready_i), .req_we_o(req_we_o), .req_addr_o(req_addr_o),
    .req_wstrb_o(req_wstrb_o), .req_wdata_o(req_wdata_o),
    .resp_valid_i(resp_valid_i), .resp_data_i(resp_data_i), .err_o(err_o)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    nChecks++;
    if (obs !== exp) begin
      nFails++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic checkReq(input reqExp_t e);
    checkOutput("reqValid", req_valid_o, 1'b1);
    checkOutput("reqWe", req_we_o, e.we);
    checkOutput("reqAddr", req_addr_o, e.addr);
    checkOutput("reqStrb", req_wstrb_o, e.strb);
    checkOutput("reqWdata", req_wdata_o, e.wdata);
  endtask

  task automatic checkResetValues(input string tag);
    checkOutput({tag, "Valid"}, req_valid_o, 1'b0);
    checkOutput({tag, "We"}, req_we_o, 1'b0);
    checkOutput({tag, "Addr"}, req_addr_o, 32'h0);
    checkOutput({tag, "Strb"}, req_wstrb_o, 4'h0);
    checkOutput({tag, "Wdata"}, req_wdata_o, 32'h0);
    checkOutput({tag, "Rdata"}, rdata_o, 32'h0);
    checkOutput({tag, "Err"}, err_o, 1'b0);
  endtask

  // Starts at a negedge with the DUT in IDLE and ends at the negedge of the IDLE cycle after DONE.
  task automatic applyStimulus(input logic we, input logic [31:0] addr, input logic [3:0] sel,
                               input logic [31:0] wdata, input int readyDelay, input int respDelay,
                               input logic [31:0] respData);
    reqExp_t     e;
    logic [31:0] expR;
    ce_i = 1'b1; we_i = we; addr_i = addr; sel_i = sel; wdata_i = wdata;
    #1;
    checkOutput("idleValid", req_valid_o, 1'b0);
    checkOutput("idleStall", stall_o, 1'b1);
    e.we = we; e.addr = {addr[31:2], 2'b00}; e.strb = sel; e.wdata = wdata;
    reqQ.push_back(e);
    if (!we) modelRdata = respData;
    rdQ.push_back(modelRdata);
    @(negedge clk);
    ce_i = 1'b0; we_i = $urandom_range(0, 1); addr_i = $urandom; sel_i = 4'($urandom); wdata_i = $urandom;
    for (int i = 0; i < readyDelay; i++) begin
      #1;
      checkReq(reqQ[0]);
      checkOutput("waitStall", stall_o, 1'b1);
      @(negedge clk);
    end
    req_ready_i = 1'b1;
    #1;
    checkReq(reqQ.pop_front());
    checkOutput("hsStall", stall_o, 1'b1);
    @(negedge clk);
    req_ready_i = 1'b0;
    for (int i = 0; i < respDelay; i++) begin
      #1;
      checkOutput("respWaitStall", stall_o, 1'b1);
      checkOutput("respWaitValid", req_valid_o, 1'b0);
      @(negedge clk);
    end
    resp_valid_i = 1'b1; resp_data_i = respData;
    #1;
    checkOutput("respStall", stall_o, 1'b1);
    @(negedge clk);
    resp_valid_i = 1'b0; resp_data_i = $urandom;
    #1;
    checkOutput("doneStall", stall_o, 1'b0);
    expR = rdQ.pop_front();
    checkOutput("doneRdata", rdata_o, expR);
    @(negedge clk);
  endtask

  initial begin
    rst = 1'b1; ce_i = 0; we_i = 0; flush_i = 0; req_ready_i = 0; resp_valid_i = 0;
    sel_i = 0; addr_i = 0; wdata_i = 0; resp_data_i = 0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    #1;
    checkResetValues("rst");
    checkOutput("rstStall", stall_o, 1'b0);
    @(negedge clk);

    // Zero-wait load, store with backpressure, then back-to-back load/store.
    applyStimulus(1'b0, 32'h1C00_0006, 4'b0011, 32'h0, 0, 0, 32'hDEAD_BEEF);
    applyStimulus(1'b1, 32'h1C00_0012, 4'b0100, 32'h5A5A_5A5A, 4, 2, 32'hFFFF_0000);
    applyStimulus(1'b0, 32'h0000_0100, 4'b1111, 32'h0, 0, 1, 32'h1111_2222);
    applyStimulus(1'b1, 32'h0000_0104, 4'b1111, 32'hA5A5_0F0F, 1, 0, 32'h3333_4444);

    // Flush while REQ waits for ready.
    ce_i = 1'b1; we_i = 1'b0; addr_i = 32'h300; sel_i = 4'hF;
    @(negedge clk);
    ce_i = 1'b0; flush_i = 1'b1;
    #1;
    checkOutput("flReqValid", req_valid_o, 1'b1);
    checkOutput("flReqStall", stall_o, 1'b0);
    @(negedge clk);
    flush_i = 1'b0;
    #1;
    checkOutput("flReqValidAfter", req_valid_o, 1'b0);
    checkOutput("flReqStallAfter", stall_o, 1'b0);
    checkOutput("flReqRdata", rdata_o, modelRdata);
    @(negedge clk);

    // Flush in RESP; a new request is held off while the late response drains.
    ce_i = 1'b1; we_i = 1'b0; addr_i = 32'h380; sel_i = 4'hF;
    @(negedge clk);
    ce_i = 1'b0; req_ready_i = 1'b1;
    @(negedge clk);
    req_ready_i = 1'b0; flush_i = 1'b1;
    #1;
    checkOutput("flRespStall", stall_o, 1'b0);
    @(negedge clk);
    flush_i = 1'b0; ce_i = 1'b1; addr_i = 32'h200;
    for (int i = 0; i < 3; i++) begin
      if (i == 2) begin resp_valid_i = 1'b1; resp_data_i = 32'hBAD0_BAD0; end
      #1;
      checkOutput("drainStall", stall_o, 1'b1);
      checkOutput("drainValid", req_valid_o, 1'b0);
      @(negedge clk);
    end
    resp_valid_i = 1'b0;
    #1;
    checkOutput("drainRdata", rdata_o, modelRdata);
    applyStimulus(1'b0, 32'h0000_0200, 4'b1111, 32'h0, 1, 1, 32'h7777_8888);

    for (int n = 0; n < 4; n++)
      applyStimulus(1'($urandom_range(0, 1)), $urandom, 4'($urandom), $urandom,
                    $urandom_range(0, 3), $urandom_range(0, 3), $urandom);

    // Reset while waiting in RESP; the response that follows must be ignored.
    ce_i = 1'b1; we_i = 1'b0; addr_i = 32'h400; sel_i = 4'hF; wdata_i = 32'h1234;
    @(negedge clk);
    ce_i = 1'b0; req_ready_i = 1'b1;
    @(negedge clk);
    req_ready_i = 1'b0; rst = 1'b1;
    @(negedge clk);
    rst = 1'b0; resp_valid_i = 1'b1; resp_data_i = 32'h1234_5678;
    #1;
    checkResetValues("midRst");
    checkOutput("midRstStall", stall_o, 1'b0);
    @(negedge clk);
    resp_valid_i = 1'b0;
    #1;
    checkOutput("lateRespRdata", rdata_o, 32'h0);
    checkOutput("lateRespStall", stall_o, 1'b0);
    modelRdata = '0;
    @(negedge clk);

`ifdef DMEM_TIMEOUT_EN
    begin
      int cyc  = 0;
      bit seen = 1'b0;
      applyStimulus(1'b0, 32'h0000_0480, 4'hF, 32'h0, 0, 0, 32'hCAFE_F00D);
      ce_i = 1'b1; we_i = 1'b0; addr_i = 32'h500; sel_i = 4'hF;
      @(negedge clk);
      ce_i = 1'b0;
      for (int k = 0; k < 50; k++) begin
        #1;
        if (err_o === 1'b1) begin seen = 1'b1; cyc = k; break; end
        @(negedge clk);
      end
      checkOutput("toSeen", seen, 1'b1);
      checkOutput("toCycles", cyc, 8);
      checkOutput("toRdata", rdata_o, 32'h0);
      checkOutput("toStall", stall_o, 1'b0);
      checkOutput("toValid", req_valid_o, 1'b0);
      @(negedge clk);
      resp_valid_i = 1'b1; resp_data_i = 32'h9999_9999;
      #1;
      checkOutput("toErrPulse", err_o, 1'b0);
      checkOutput("toIdleStall", stall_o, 1'b0);
      @(negedge clk);
      resp_valid_i = 1'b0;
      #1;
      checkOutput("toLateRdata", rdata_o, 32'h0);
      @(negedge clk);
    end
`endif

    checkOutput("finalErr", err_o, 1'b0);
    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
    $finish;
  end

endmodule
